// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared definitions for the shared-ALU controller: opcode values, the bit
// layout of the ALU instruction word P = {b, a, op}, the controller FSM
// state type and a helper that packs an instruction word.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_NAND = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  localparam int OP_LSB = 0;
  localparam int A_LSB  = 3;
  localparam int B_LSB  = 7;
  localparam int P_W    = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic [P_W-1:0] pack_p(input logic [2:0] op,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
    logic [P_W-1:0] p;
    p = '0;
    p[OP_LSB +: 3] = op;
    p[A_LSB  +: 4] = a;
    p[B_LSB  +: 4] = b;
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. Picks the first asserted request
// searching upward from ptr and wrapping from NREQ-1 back to 0.
// Ports:
//   req     in   NREQ  request vector
//   ptr     in   IDW   search start index (must be < NREQ)
//   grant   out  NREQ  one-hot grant (all zero when no request)
//   winner  out  IDW   encoded index of the granted request
//   any_req out  1     at least one request asserted
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  winner,
  output logic            any_req
);

  always_comb begin
    // One extra bit so ptr+i can exceed NREQ-1 before the wrap correction;
    // this keeps the search correct for NREQ that is not a power of two.
    logic [IDW:0] idx;
    grant   = '0;
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(NREQ)) begin
        idx = idx - (IDW+1)'(NREQ);
      end
      if (!any_req && req[idx[IDW-1:0]]) begin
        any_req                = 1'b1;
        winner                 = idx[IDW-1:0];
        grant[idx[IDW-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
// Time-shares one external registered 4-bit ALU among NREQ requesters.
// A round-robin winner is accepted in IDLE, its operands are packed into
// the ALU instruction word, the ALU's one-cycle registered latency is
// sequenced, and the captured result is returned with the requester ID on
// a valid/ready response channel.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; req_ready strobes the winner's bit
// EXEC  | alu_p stable, ALU registers its result on the closing edge
// CAPT  | alu_x valid, captured into resp_x / resp_id on the edge
// RESP  | response presented, held until resp_ready
//
// Ports:
//   clock, reset_n        clock and async active-low reset
//   req_valid/op/a/b      per-requester request and operands (packed)
//   req_ready             one-hot accept strobe, only in IDLE
//   alu_p, alu_x          instruction word to / registered result from ALU
//   resp_valid/ready/id/x response channel
//   busy                  high whenever not IDLE
//   op_count              completed responses, wraps modulo 2^CNTW
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [3*NREQ-1:0]    req_op,
  input  logic [4*NREQ-1:0]    req_a,
  input  logic [4*NREQ-1:0]    req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [P_W-1:0]       alu_p,
  input  logic [3:0]           alu_x,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [3:0]           resp_x,
  output logic                 busy,
  output logic [CNTW-1:0]      op_count
);

  state_t state_q, state_d;

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  id_r;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win;
  logic            any_req;
  logic [IDW-1:0]  ptr_next;
  logic [2:0]      sel_op;
  logic [3:0]      sel_a;
  logic [3:0]      sel_b;
  logic            load_req;
  logic            load_resp;
  logic            done;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant   (grant),
    .winner  (win),
    .any_req (any_req)
  );

  // Operand mux for the winning requester.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_op = req_op[3*i +: 3];
        sel_a  = req_a[4*i +: 4];
        sel_b  = req_b[4*i +: 4];
      end
    end
  end

  assign ptr_next = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    load_req  = 1'b0;
    load_resp = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          req_ready = grant;
          load_req  = 1'b1;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        load_resp = 1'b1;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  // alu_p is only reloaded on accept, so it stays stable through EXEC and
  // simply keeps its last value afterwards.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_p      <= '0;
      id_r       <= '0;
      rr_ptr     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_x     <= '0;
      op_count   <= '0;
    end else begin
      if (load_req) begin
        alu_p  <= pack_p(sel_op, sel_a, sel_b);
        id_r   <= win;
        rr_ptr <= ptr_next;
      end
      if (load_resp) begin
        resp_x     <= alu_x;
        resp_id    <= id_r;
        resp_valid <= 1'b1;
      end
      if (done) begin
        resp_valid <= 1'b0;
        op_count   <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;
  import alu_ctrl_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [NREQ-1:0]   req_valid;
  logic [3*NREQ-1:0] req_op;
  logic [4*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready, req_ready4;
  logic [P_W-1:0]    alu_p, alu_p4;
  logic [3:0]        alu_x, alu_x4;
  logic              resp_valid, resp_valid4, resp_ready;
  logic [IDW-1:0]    resp_id, resp_id4;
  logic [3:0]        resp_x, resp_x4;
  logic              busy, busy4;
  logic [CNTW-1:0]   op_count;
  logic [3:0]        op_count4;

  bit         r_v [NREQ];
  logic [2:0] r_op[NREQ];
  logic [3:0] r_a [NREQ];
  logic [3:0] r_b [NREQ];

  always_comb begin
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]      = r_v[i];
      req_op[3*i +: 3]  = r_op[i];
      req_a[4*i +: 4]   = r_a[i];
      req_b[4*i +: 4]   = r_b[i];
    end
  end

  alu_share_ctrl #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .alu_p(alu_p),
    .alu_x(alu_x), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_x(resp_x), .busy(busy), .op_count(op_count)
  );

  alu_share_ctrl #(.NREQ(NREQ), .IDW(IDW), .CNTW(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready4), .alu_p(alu_p4),
    .alu_x(alu_x4), .resp_valid(resp_valid4), .resp_ready(resp_ready),
    .resp_id(resp_id4), .resp_x(resp_x4), .busy(busy4), .op_count(op_count4)
  );

  // Reference ALU semantics: 4-bit modulo result.
  function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      default: r = ~(a ^ b);
    endcase
    return r;
  endfunction

  // External registered ALUs driven by each controller's instruction word.
  always_ff @(posedge clock) begin
    alu_x  <= alu_ref(alu_p[OP_LSB +: 3], alu_p[A_LSB +: 4], alu_p[B_LSB +: 4]);
    alu_x4 <= alu_ref(alu_p4[OP_LSB +: 3], alu_p4[A_LSB +: 4], alu_p4[B_LSB +: 4]);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int first_set(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic [IDW-1:0] id;
    logic [3:0]     x;
    int             gcyc;
  } exp_t;

  exp_t        exp_q[$];
  int          exp_ptr = 0;
  bit          exp_busy = 1'b0;
  bit          resp_active = 1'b0;
  logic [3:0]  held_x;
  logic [IDW-1:0] held_id;
  logic [P_W-1:0] exp_p = '0;
  int unsigned exp_count = 0;

  initial begin
    int exp_w;
    int idx;
    logic [NREQ-1:0] exp_grant;
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        exp_ptr = 0; exp_busy = 1'b0; resp_active = 1'b0; exp_p = '0; exp_count = 0;
        exp_q.delete();
        chk("rst_outputs", 32'({resp_valid, busy, req_ready, alu_p, resp_x, resp_id}), 32'(0));
        chk("rst_op_count", 32'(op_count), 32'(0));
      end else begin
        exp_w = -1;
        if (!exp_busy) begin
          for (int k = 0; k < NREQ; k++) begin
            idx = (exp_ptr + k) % NREQ;
            if (exp_w < 0 && r_v[idx]) exp_w = idx;
          end
        end
        exp_grant = (exp_w >= 0) ? (NREQ'(1) << exp_w) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_grant));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("alu_p", 32'(alu_p), 32'(exp_p));
        chk("op_count", 32'(op_count), 32'(exp_count[CNTW-1:0]));
        chk("op_count_w4", 32'(op_count4), 32'(exp_count[3:0]));

        if (resp_active) begin
          chk("resp_hold_valid", 32'(resp_valid), 32'(1));
          chk("resp_hold_x", 32'(resp_x), 32'(held_x));
          chk("resp_hold_id", 32'(resp_id), 32'(held_id));
        end else if (resp_valid) begin
          if (exp_q.size() == 0) begin
            chk("resp_unexpected", 32'(resp_valid), 32'(0));
          end else begin
            e = exp_q.pop_front();
            chk("resp_id", 32'(resp_id), 32'(e.id));
            chk("resp_x", 32'(resp_x), 32'(e.x));
            chk("resp_latency", 32'(cyc - e.gcyc), 32'(3));
            held_x = e.x; held_id = e.id; resp_active = 1'b1;
          end
        end

        if (resp_active && resp_valid && resp_ready) begin
          resp_active = 1'b0;
          exp_busy    = 1'b0;
          exp_count++;
        end
        if (exp_w >= 0) begin
          e.id   = IDW'(exp_w);
          e.x    = alu_ref(r_op[exp_w], r_a[exp_w], r_b[exp_w]);
          e.gcyc = cyc;
          exp_q.push_back(e);
          exp_p    = pack_p(r_op[exp_w], r_a[exp_w], r_b[exp_w]);
          exp_ptr  = (exp_w + 1) % NREQ;
          exp_busy = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    r_op[i] = op; r_a[i] = a; r_b[i] = b; r_v[i] = 1'b1;
  endtask

  task automatic set_rand(input int i);
    set_req(i, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  task automatic wait_any(input string nm, output int w, output int gc);
    w = -1; gc = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if (req_ready != '0) begin
        w = first_set(req_ready); gc = cyc;
        return;
      end
    end
    chk(nm, 32'(0), 32'(1));
  endtask

  // Waits for the grant, checks it went to i, then consumes the request.
  task automatic wait_grant(input string nm, input int i);
    int w, gc;
    wait_any({nm, "_timeout"}, w, gc);
    chk(nm, 32'(w), 32'(i));
    tick();
    r_v[i] = 1'b0;
  endtask

  task automatic wait_resp(input string nm);
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if (resp_valid) return;
    end
    chk(nm, 32'(0), 32'(1));
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (!busy) begin
        tick();
        return;
      end
    end
    chk("idle_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int w, gc, prev, g;
    logic [3:0] sx;
    logic [IDW-1:0] sid;
    for (int i = 0; i < NREQ; i++) begin
      r_v[i] = 1'b0; r_op[i] = '0; r_a[i] = '0; r_b[i] = '0;
    end
    resp_ready = 1'b0;
    repeat (3) tick();
    chk("reset_alu_p", 32'(alu_p), 32'(0));
    chk("reset_resp_valid", 32'(resp_valid), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_op_count", 32'(op_count), 32'(0));
    reset_n = 1'b1;
    tick();

    // Requester 0 alone: 3 - 5 = 0xE.
    resp_ready = 1'b1;
    set_req(0, OP_SUB, 4'd3, 4'd5);
    wait_grant("t1_grant", 0);
    @(negedge clock);
    chk("t1_alu_p", 32'(alu_p), 32'(11'b0101_0011_001));
    @(negedge clock);
    chk("t1_not_yet_valid", 32'(resp_valid), 32'(0));
    @(negedge clock);
    chk("t1_resp_valid", 32'(resp_valid), 32'(1));
    chk("t1_resp_x", 32'(resp_x), 32'(4'hE));
    chk("t1_resp_id", 32'(resp_id), 32'(0));
    @(negedge clock);
    chk("t1_op_count", 32'(op_count), 32'(1));
    tick();

    // Requester 2: ADD wrap, then XNOR.
    set_req(2, OP_ADD, 4'd9, 4'd9);
    wait_grant("t2_grant_add", 2);
    wait_resp("t2_resp_add_timeout");
    chk("t2_add_x", 32'(resp_x), 32'(4'h2));
    chk("t2_add_id", 32'(resp_id), 32'(2));
    tick();
    set_req(2, OP_XNOR, 4'hA, 4'h5);
    wait_grant("t2_grant_xnor", 2);
    wait_resp("t2_resp_xnor_timeout");
    chk("t2_xnor_x", 32'(resp_x), 32'(4'h0));
    tick();

    // All requesters continuously valid: 0,1,2,3,0 every 4 cycles.
    do_reset();
    resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_rand(i);
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_any("t3_grant_timeout", w, gc);
      chk("t3_order", 32'(w), 32'(n % NREQ));
      if (n > 0) chk("t3_spacing", 32'(gc - prev), 32'(4));
      prev = gc;
      tick();
      if (w >= 0) set_rand(w);
    end
    for (int i = 0; i < NREQ; i++) r_v[i] = 1'b0;
    wait_idle();

    // Wrap-around search: drive pointer to 3, then only req1.
    set_rand(2);
    wait_grant("t4_pre", 2);
    wait_idle();
    set_rand(1);
    wait_grant("t4_wrap", 1);
    wait_idle();
    set_rand(1);
    set_rand(3);
    wait_grant("t4_ptr_after_wrap", 3);
    wait_grant("t4_next", 1);
    wait_idle();

    // Backpressure: response held for 5 cycles, no grants meanwhile.
    resp_ready = 1'b0;
    set_rand(0);
    set_rand(1);
    wait_grant("t5_grant", 0);
    wait_resp("t5_resp_timeout");
    sx = resp_x; sid = resp_id;
    for (int n = 0; n < 5; n++) begin
      @(negedge clock);
      chk("t5_valid_stable", 32'(resp_valid), 32'(1));
      chk("t5_x_stable", 32'(resp_x), 32'(sx));
      chk("t5_id_stable", 32'(resp_id), 32'(sid));
      chk("t5_no_grant", 32'(req_ready), 32'(0));
      chk("t5_busy", 32'(busy), 32'(1));
    end
    tick();
    resp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("t5_released_idle", 32'(busy), 32'(0));
    chk("t5_next_grant", 32'(req_ready), 32'(4'b0010));
    tick();
    r_v[1] = 1'b0;
    wait_idle();

    // Reset during EXEC: everything clears, no response afterwards.
    set_rand(3);
    wait_grant("t6_grant", 3);
    reset_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(resp_valid), 32'(0));
    chk("t6_async_busy", 32'(busy), 32'(0));
    chk("t6_async_alu_p", 32'(alu_p), 32'(0));
    chk("t6_async_ready", 32'(req_ready), 32'(0));
    repeat (2) tick();
    reset_n = 1'b1;
    set_rand(1);
    set_rand(3);
    @(negedge clock);
    chk("t6_first_after_reset", 32'(req_ready), 32'(4'b0010));
    tick();
    r_v[1] = 1'b0;
    wait_grant("t6_second", 3);
    wait_idle();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      g = first_set(req_ready);
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (i == g) r_v[i] = 1'b0;
        else if (!r_v[i] && $urandom_range(0, 2) == 0) set_rand(i);
        else if (r_v[i] && $urandom_range(0, 19) == 0) r_v[i] = 1'b0;
      end
      resp_ready = ($urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < NREQ; i++) r_v[i] = 1'b0;
    resp_ready = 1'b1;
    wait_idle();
    repeat (2) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    chk("min_completions", 32'(exp_count >= 20), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Time-shares one registered 4-bit ALU instance (11-bit instruction word P = {b[3:0], a[3:0], op[2:0]}, result X registered on the clock edge) among NREQ requesters. Round-robin arbitration selects one requester, packs its operands into P and sequences the ALU's one-cycle registered latency. It then returns the captured result, tagged with the requester ID, over a valid/ready response channel. Sits between client blocks and the single alu instance; the alu itself is instantiated outside this block.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester ID width, must equal clog2(NREQ)
CNTW, 16, width of the completed-operation counter

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_op  in  3*NREQ  opcode, requester i at [3i+2:3i]
req_a  in  4*NREQ  operand a, requester i at [4i+3:4i]
req_b  in  4*NREQ  operand b, requester i at [4i+3:4i]
req_ready  out  NREQ  one-hot grant/accept strobe
alu_p  out  11  instruction word to ALU, {b,a,op}
alu_x  in  4  registered ALU result
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts response
resp_id  out  IDW  requester index of the response
resp_x  out  4  result
busy  out  1  high in any state other than IDLE
op_count  out  CNTW  completed responses, wraps modulo 2^CNTW

Behaviour:
- Reset (async assert, sync-to-clock release): state=IDLE, rr_ptr=0, alu_p=0, resp_valid=0, resp_id=0, resp_x=0, op_count=0, req_ready=0, busy=0.
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE: if any req_valid, winner = first set bit searching upward from rr_ptr, wrapping at NREQ-1 to 0.
  - req_ready is combinational: req_ready[winner]=1 only in IDLE; all other bits 0. Handshake completes in this same cycle.
  - On the edge: alu_p <= {req_b[w], req_a[w], req_op[w]}, id_r <= w, rr_ptr <= (w+1) mod NREQ, next = EXEC.
  - No req_valid: remain in IDLE with no change.
- EXEC: alu_p held stable; the ALU registers X on this cycle's closing edge. next = CAPT.
- CAPT: alu_x is valid. On the edge: resp_x <= alu_x, resp_id <= id_r, resp_valid <= 1, next = RESP.
- RESP: resp_valid, resp_id and resp_x held stable until resp_ready=1.
  - On the edge with resp_ready=1: resp_valid <= 0, op_count <= op_count+1 (wraps), next = IDLE.
  - resp_ready may be high before RESP; it is ignored outside RESP.
- Latency: accept in cycle n gives resp_valid high from cycle n+3. Peak throughput is 1 op per 4 cycles.
- alu_p holds its last value outside EXEC; the ALU output changing afterwards is harmless because resp_x is already captured.
- Requesters must hold req_valid and their operands until req_ready. Dropping req_valid before grant is allowed (no grant is issued).
- A winner's request is consumed once; it must re-assert for another op. No new grant is issued while busy.
- Arithmetic is the ALU's 4-bit modulo result; this block does no arithmetic on data.
- Reset mid-operation: any in-flight op is discarded with no response; rr_ptr returns to 0.

Decomposition:
- Package alu_ctrl_pkg:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_XOR=2, OP_OR=3, OP_AND=4, OP_NOR=5, OP_NAND=6, OP_XNOR=7
  - P field positions: OP_LSB=0, A_LSB=3, B_LSB=7, P_W=11
  - FSM state enum (2 bits)
- Sub-module rr_arbiter (parameter NREQ): inputs req vector and ptr; outputs one-hot grant, encoded winner and any_req. Purely combinational, reusable.

Test Plan:
- Req0 only, op=1, a=3, b=5 → req_ready[0] high 1 cycle, alu_p=11'b0101_0011_001, resp_valid at n+3 with resp_x=4'hE, resp_id=0, op_count=1.
- Req2 only, op=0, a=9, b=9 → resp_x=4'h2 (wrap), resp_id=2; then op=7, a=4'hA, b=4'h5 → resp_x=4'h0.
- All 4 requesters valid continuously, resp_ready=1 → grant order 0,1,2,3,0, one grant every 4 cycles, resp_id follows the same sequence.
- rr_ptr=3 with only req1 valid → req1 granted (wrap search), next rr_ptr=2.
- resp_ready held low 5 cycles in RESP → resp_valid, resp_id and resp_x stable, no req_ready asserted, busy=1; release → IDLE next cycle.
- reset_n low during EXEC → outputs zero immediately (async), no response after release, next grant goes to lowest valid requester from index 0.
- op_count preset near wrap (CNTW=4 build, 16 completions) → op_count returns to 0.
